imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_decode.sv | 27 ++
 rtl/imm_extend_pipe.sv | 88 ++++++++
 tb/tb_imm_extend_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-format encodings, default width and legality helper
package imm_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    function automatic logic imm_src_legal(input logic [2:0] src);
        return src <= IMM_U;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RISC-V immediate extraction and sign extension
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            err
);

    logic [31:0] w_imm32;

    // build the 32-bit immediate; every format carries instr[31] in bit 31 so one sign extension serves all
    always_comb begin
        w_imm32 = (immsrc == IMM_I) ? {{20{instr[31]}}, instr[31:20]}
                : (immsrc == IMM_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
                : (immsrc == IMM_B) ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}
                : (immsrc == IMM_J) ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}
                : (immsrc == IMM_U) ? {instr[31:12], 12'h000}
                : 32'h0;
        err     = !imm_src_legal(immsrc);
        immext  = XLEN'($signed(w_imm32));
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready pipeline producing sign-extended immediates
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:7]      instr,
    input  logic [2:0]       immsrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immext,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    logic             r_s1_v;
    logic [31:7]      r_s1_instr;
    logic [2:0]       r_s1_src;
    logic             r_s2_v;
    logic [XLEN-1:0]  r_s2_imm;
    logic             r_s2_err;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s1_en;
    logic             w_s2_en;
    logic [XLEN-1:0]  w_imm;
    logic             w_err;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr  (r_s1_instr),
        .immsrc (r_s1_src),
        .immext (w_imm),
        .err    (w_err)
    );

    // a stage may load when it is empty or its occupant leaves this cycle; depends only on state and out_ready
    always_comb begin
        w_s2_en = !r_s2_v || out_ready;
        w_s1_en = !r_s1_v || w_s2_en;
    end

    assign in_ready  = w_s1_en;
    assign out_valid = r_s2_v;
    assign immext    = r_s2_imm;
    assign out_err   = r_s2_err;
    assign out_count = r_cnt;

    // stage 1: capture the raw instruction fields on an input transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v     <= 1'b0;
            r_s1_instr <= '0;
            r_s1_src   <= '0;
        end else if (w_s1_en) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_instr <= instr;
                r_s1_src   <= immsrc;
            end
        end
    end

    // stage 2: capture the decoded result, holding it while the output is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_v   <= 1'b0;
            r_s2_imm <= '0;
            r_s2_err <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_imm <= w_imm;
                r_s2_err <= w_err;
            end
        end
    end

    // count completed output transfers, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else if (r_s2_v && out_ready) r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench driving a 32-bit and a 64-bit (2-bit counter) instance in lockstep
module tb_imm_extend_pipe;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready;
    logic [31:7] instr;
    logic [2:0]  immsrc;

    logic        a_in_ready, a_out_valid, a_err;
    logic [31:0] a_imm;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_err;
    logic [63:0] b_imm;
    logic [1:0]  b_cnt;

    int n_chk = 0;
    int n_fail = 0;

    vec_t vecs[13];
    vec_t qa[$];
    vec_t qb[$];
    logic [15:0] ma_cnt = '0;
    logic [1:0]  mb_cnt = '0;
    logic [1:0]  cnt_log[$];
    bit          log_pend = 0;
    bit          hold_v = 0;
    logic [31:0] hold_imm;
    logic        hold_err;
    bit          bp_done;
    time         t0;
    int          wrap_exp[5] = '{1, 2, 3, 0, 1};

    imm_extend_pipe #(.XLEN(32), .CNT_W(16)) u_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .instr     (instr),
        .immsrc    (immsrc),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .immext    (a_imm),
        .out_err   (a_err),
        .out_count (a_cnt)
    );

    imm_extend_pipe #(.XLEN(64), .CNT_W(2)) u_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .instr     (instr),
        .immsrc    (immsrc),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .immext    (b_imm),
        .out_err   (b_err),
        .out_count (b_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int k);
        bit ok = 0;
        in_valid = 1'b1;
        instr    = vecs[k].ins[31:7];
        immsrc   = vecs[k].src;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1;
                qa.push_back(vecs[k]);
                qb.push_back(vecs[k]);
            end
        end
        if (!ok) chk("send_accept", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge clk);
        chk("drain_empty", 64'(qa.size() + qb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // monitor: pops expected results on every output transfer and checks counters and stall stability
    always @(negedge clk) begin
        vec_t v;
        if (reset) begin
            qa.delete();
            qb.delete();
            cnt_log.delete();
            ma_cnt   = '0;
            mb_cnt   = '0;
            log_pend = 0;
            hold_v   = 0;
        end else begin
            if (log_pend) cnt_log.push_back(b_cnt);
            log_pend = 0;
            chk("a_count", 64'(a_cnt), 64'(ma_cnt));
            chk("b_count", 64'(b_cnt), 64'(mb_cnt));
            if (hold_v) begin
                chk("stall_valid", 64'(a_out_valid), 64'd1);
                chk("stall_imm", 64'(a_imm), 64'(hold_imm));
                chk("stall_err", 64'(a_err), 64'(hold_err));
            end
            hold_v   = a_out_valid && !out_ready;
            hold_imm = a_imm;
            hold_err = a_err;
            if (a_out_valid && out_ready) begin
                chk("a_expected_pending", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    v = qa.pop_front();
                    chk("a_immext", 64'(a_imm), 64'(v.e64[31:0]));
                    chk("a_err", 64'(a_err), 64'(v.err));
                end
                ma_cnt = ma_cnt + 16'd1;
            end
            if (b_out_valid && out_ready) begin
                chk("b_expected_pending", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) begin
                    v = qb.pop_front();
                    chk("b_immext", b_imm, v.e64);
                    chk("b_err", 64'(b_err), 64'(v.err));
                end
                mb_cnt   = mb_cnt + 2'd1;
                log_pend = 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{
            '{32'h80000013, 3'd0, 64'hFFFFFFFFFFFFF800, 1'b0},
            '{32'hFE000FE3, 3'd2, 64'hFFFFFFFFFFFFFFFE, 1'b0},
            '{32'h0010006F, 3'd3, 64'h0000000000000800, 1'b0},
            '{32'h12345037, 3'd4, 64'h0000000012345000, 1'b0},
            '{32'h80000037, 3'd4, 64'hFFFFFFFF80000000, 1'b0},
            '{32'hFFFFFFFF, 3'd6, 64'h0000000000000000, 1'b1},
            '{32'h00A00423, 3'd1, 64'h0000000000000008, 1'b0},
            '{32'h7FF00093, 3'd0, 64'h00000000000007FF, 1'b0},
            '{32'h00000463, 3'd2, 64'h0000000000000008, 1'b0},
            '{32'hFFDFF06F, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0},
            '{32'h12345678, 3'd5, 64'h0000000000000000, 1'b1},
            '{32'h5555AAAA, 3'd7, 64'h0000000000000000, 1'b1},
            '{32'hFE000FA3, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0}
        };
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 25'h1FFFFFF;
        immsrc    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_immext", 64'(a_imm), 64'd0);
        chk("rst_a_err", 64'(a_err), 64'd0);
        chk("rst_a_count", 64'(a_cnt), 64'd0);
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_immext", b_imm, 64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        repeat (2) begin
            @(negedge clk);
            chk("rst_ignored_in_valid", 64'(a_out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(0);
        @(negedge clk);
        chk("latency_cycle1", 64'(a_out_valid), 64'd0);
        @(negedge clk);
        chk("latency_cycle2", 64'(a_out_valid), 64'd1);
        drain();
        @(posedge clk);
        #1;
        t0 = $time;
        for (int k = 0; k < 13; k++) send(k);
        chk("throughput_cycles", 64'(($time - t0) / 10), 64'd13);
        drain();
        @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b0;
        bp_done   = 0;
        fork
            begin
                send(0);
                send(1);
                send(2);
                bp_done = 1;
            end
        join_none
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        chk("bp_accepted", 64'(qa.size()), 64'd2);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int n = 0; n < 50 && !bp_done; n++) @(negedge clk);
        chk("bp_third_accepted", 64'(bp_done), 64'd1);
        drain();
        chk("bp_a_count", 64'(a_cnt), 64'd3);
        chk("bp_b_count", 64'(b_cnt), 64'd3);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(1);
        send(3);
        chk("mf_in_flight", 64'(qa.size()), 64'd2);
        do_reset();
        @(negedge clk);
        chk("mf_out_valid", 64'(a_out_valid), 64'd0);
        chk("mf_a_count", 64'(a_cnt), 64'd0);
        chk("mf_b_count", 64'(b_cnt), 64'd0);
        chk("mf_in_ready", 64'(a_in_ready), 64'd1);
        chk("mf_immext", 64'(a_imm), 64'd0);
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("mf_no_stale", 64'(a_out_valid | b_out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < 5; k++) send(k);
        drain();
        @(negedge clk);
        chk("wrap_log_len", 64'(cnt_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < cnt_log.size(); i++)
            chk($sformatf("wrap_count_%0d", i), 64'(cnt_log[i]), 64'(wrap_exp[i]));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
